// File: rtl/if_stage_if.sv
// if_stage_if: bus bundle for the instruction-fetch stage.
//   Control inputs : stall, branch_taken, branch_target
//   Memory side    : imem_read/imem_addr out, imem_rdata/imem_busy in
//   IF/ID register : pc_out, pc_plus4_out, instr_out, instr_valid
// Modport master is the fetch stage, slave is its environment
// (hazard unit, EX redirect, instruction memory, ID stage).
interface if_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_busy;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;
    logic        instr_valid;

    modport master (
        input  stall, branch_taken, branch_target, imem_rdata, imem_busy,
        output imem_read, imem_addr, pc_out, pc_plus4_out, instr_out, instr_valid
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_rdata, imem_busy,
        input  imem_read, imem_addr, pc_out, pc_plus4_out, instr_out, instr_valid
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: RV32IM instruction-fetch stage.
// Owns the PC, issues word fetches over a read/busy handshake, buffers a
// completed word while the pipeline is stalled and drives the IF/ID register.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - if_stage_if.master (control, imem handshake, IF/ID outputs)
// A redirect while a fetch is outstanding moves to DROP, which keeps the
// abandoned address on the bus until memory accepts it, then discards it.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_drop_addr;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc4_out;
    logic [31:0] r_instr;
    logic        r_valid;

    logic        w_read;
    logic        w_complete;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Request is gated by reset so nothing is presented to memory while the
    // shared reset is asserted, even though the reset state is FETCH.
    assign w_read     = !reset && (r_state != S_HOLD);
    assign w_complete = w_read && !bus.imem_busy;
    assign w_target   = bus.branch_target & ~32'd3;
    assign w_pc_plus4 = r_pc + 32'd4;

    assign bus.imem_read    = w_read;
    assign bus.imem_addr    = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign bus.pc_out       = r_pc_out;
    assign bus.pc_plus4_out = r_pc4_out;
    assign bus.instr_out    = r_instr;
    assign bus.instr_valid  = r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_buf       <= '0;
            r_drop_addr <= '0;
            r_pc_out    <= '0;
            r_pc4_out   <= '0;
            r_instr     <= NOP_INSTR;
            r_valid     <= 1'b0;
        end else if (bus.branch_taken) begin
            // Flush IF/ID; pc fields keep their last value.
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_pc    <= w_target;
            case (r_state)
                S_FETCH: begin
                    if (!w_complete) begin
                        r_state     <= S_DROP;
                        r_drop_addr <= r_pc;
                    end
                end
                S_HOLD:  r_state <= S_FETCH;
                S_DROP:  if (w_complete) r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_complete) begin
                        if (bus.stall) begin
                            r_buf   <= bus.imem_rdata;
                            r_state <= S_HOLD;
                        end else begin
                            r_pc_out  <= r_pc;
                            r_pc4_out <= w_pc_plus4;
                            r_instr   <= bus.imem_rdata;
                            r_valid   <= 1'b1;
                            r_pc      <= w_pc_plus4;
                        end
                    end else if (!bus.stall) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!bus.stall) begin
                        r_pc_out  <= r_pc;
                        r_pc4_out <= w_pc_plus4;
                        r_instr   <= r_buf;
                        r_valid   <= 1'b1;
                        r_pc      <= w_pc_plus4;
                        r_state   <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (w_complete) r_state <= S_FETCH;
                    if (!bus.stall) begin
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the RV32IM pipeline, sitting directly upstream of the ID stage and its control unit. It owns the program counter and issues word fetches to instruction memory over a request/busy handshake. It buffers a fetched word while the pipeline is stalled and delivers the IF/ID pipeline register (pc, pc+4, instruction, valid) to ID. Taken branches and jumps from EX redirect the PC and flush IF/ID, including discarding a fetch already in flight.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000013, instruction word driven on instr_out for bubbles (ADDI x0,x0,0).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard unit request: hold IF/ID and PC
branch_taken  in  1  EX-stage redirect (taken branch/JAL/JALR)
branch_target  in  32  redirect address; bits [1:0] are ignored and forced to 00
imem_read  out  1  fetch request, held until accepted
imem_addr  out  32  fetch address, stable while imem_read=1
imem_rdata  in  32  fetch data, valid in the cycle imem_read=1 and imem_busy=0
imem_busy  in  1  memory not ready; fetch completes at an edge with imem_read=1 and imem_busy=0
pc_out  out  32  IF/ID: PC of instr_out
pc_plus4_out  out  32  IF/ID: pc_out+4 (mod 2^32)
instr_out  out  32  IF/ID: instruction word
instr_valid  out  1  IF/ID: 1 = real instruction, 0 = bubble

Behaviour:
- Reset (asynchronous): pc=RESET_PC, state=FETCH, buffer empty. Outputs: pc_out=0, pc_plus4_out=0, instr_out=NOP_INSTR, instr_valid=0. imem_read=0 while reset is high.
- States:
  - FETCH: imem_read=1, imem_addr=pc.
  - HOLD: imem_read=0; buffer holds the completed word.
  - DROP: imem_read=1, imem_addr=address of the abandoned fetch (held stable).
- "complete" means imem_read=1 and imem_busy=0 at the clock edge.
- Priority at each edge: branch_taken > stall > normal.
- branch_taken: IF/ID flushed (instr_out=NOP_INSTR, instr_valid=0; pc_out and pc_plus4_out unchanged). pc <= {branch_target[31:2],2'b00}. Buffer is discarded.
  - From FETCH with busy=1: go to DROP; the abandoned address is latched.
  - From FETCH with complete: data is discarded; stay in FETCH.
  - From HOLD: go to FETCH.
  - From DROP: pc is updated to the new target; remain in DROP until the old fetch completes.
- FETCH, complete, stall=0: IF/ID <= {pc, pc+4, imem_rdata, 1}; pc <= pc+4. Sustained rate is one instruction per cycle, with fetch-to-IF/ID latency of 1 edge.
- FETCH, complete, stall=1: buffer <= imem_rdata; go to HOLD. pc and IF/ID are held.
- FETCH, busy=1: if stall=1, IF/ID is held; if stall=0, IF/ID <= bubble (NOP_INSTR, valid=0, pc fields unchanged).
- HOLD, stall=1: everything is held. No memory request is issued.
- HOLD, stall=0: IF/ID <= {pc, pc+4, buffer, 1}; pc <= pc+4; go to FETCH.
- DROP, complete: data is discarded; go to FETCH, which fetches the current pc on the next cycle. While in DROP, IF/ID takes a bubble if stall=0 and holds if stall=1.
- pc+4 wraps modulo 2^32: pc 32'hFFFFFFFC yields pc_plus4 32'h00000000.
- Reset asserted mid-DROP or mid-HOLD: immediate return to the reset state. The instruction memory shares the same reset, so no stale request survives.

Test Plan:
- Reset, then busy=0 and memory returns addr-derived data (rdata = addr ^ 32'hA5A5A5A5): instr_valid rises 1 edge after reset release. pc_out sequence is 0,4,8,12 on consecutive cycles; instr_out matches the data.
- Hold busy=1 for 3 cycles at pc=8: imem_addr=8 is held stable; 3 bubbles are produced (valid=0, NOP); the word for 8 appears the cycle after busy falls.
- stall=1 while the fetch of pc=12 completes: HOLD is entered, imem_read=0, and IF/ID keeps pc_out=8. After stall drops, pc_out=12 with the buffered word, then fetching resumes at 16.
- branch_taken with target 32'h00000103 while FETCH at pc=20 has busy=1: instr_valid=0 on the next edge; imem_addr stays 20 until busy=0; then imem_addr=32'h100; the first valid output has pc_out=32'h100.
- branch_taken and stall both asserted in HOLD: the flush wins, valid=0, and fetch restarts at the target on the next cycle.
- Start at RESET_PC=32'hFFFFFFF8: pc_plus4_out reads FFFFFFFC, then 00000000. Also assert reset mid-DROP: outputs return to reset values immediately and imem_read=0.
